// File: rtl/dcache_flush_ctrl.sv
// Flush sequencer for the data cache: drains the miss unit, then walks every set, writes back the dirty ways and invalidates the set.
// Build option: define DCACHE_FLUSH_WBCNT_EN to count write-backs per sweep on flush_wb_cnt_o (tied to 0 otherwise).
module dcache_flush_ctrl #(
  parameter  int NUM_SETS = 256,
  parameter  int NUM_WAYS = 8,
  parameter  int TAG_W    = 44,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  output logic                      flushing_o,
  output logic                      flush_ack_o,
  input  logic                      miss_busy_i,
  output logic                      sram_req_o,
  output logic                      sram_we_o,
  output logic [IDX_W-1:0]          sram_index_o,
  input  logic                      sram_gnt_i,
  input  logic [NUM_WAYS-1:0]       valid_i,
  input  logic [NUM_WAYS-1:0]       dirty_i,
  input  logic [NUM_WAYS*TAG_W-1:0] tag_i,
  output logic                      wb_req_o,
  output logic [IDX_W-1:0]          wb_index_o,
  output logic [WAY_W-1:0]          wb_way_o,
  output logic [TAG_W-1:0]          wb_tag_o,
  input  logic                      wb_ack_i,
  output logic [15:0]               flush_wb_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_INVAL = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  // Handshakes (sram_req_o/sram_gnt_i, wb_req_o/wb_ack_i): the request and its payload stay
  // stable until the responder is high; the transfer happens in that cycle, even the first one.
  logic [2:0]                r_state;
  logic [IDX_W-1:0]          r_set;
  logic                      r_armed;
  logic [NUM_WAYS-1:0]       r_mask;
  logic [NUM_WAYS*TAG_W-1:0] r_tags;

  logic                      w_start;
  logic                      w_last_set;
  logic [WAY_W-1:0]          w_way;
  logic [NUM_WAYS-1:0]       w_way_oh;
  logic [NUM_WAYS-1:0]       w_dirty;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_in_wb;

  assign w_start    = (r_state == S_IDLE) && flush_i && r_armed;
  assign w_last_set = (r_set == IDX_W'(NUM_SETS - 1));
  assign w_dirty    = valid_i & dirty_i;
  assign w_in_wb    = (r_state == S_WB);

  // Lowest pending way wins.
  always_comb begin
    w_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (r_mask[i]) w_way = WAY_W'(i);
    end
  end

  assign w_way_oh = NUM_WAYS'(1) << w_way;
  assign w_tag    = r_tags[w_way*TAG_W +: TAG_W];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_set   <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_DRAIN;
            r_set   <= '0;
          end
        end
        S_DRAIN: if (!miss_busy_i) r_state <= S_READ;
        S_READ:  if (sram_gnt_i) r_state <= S_CHECK;
        S_CHECK: begin
          r_mask  <= w_dirty;
          r_state <= (|w_dirty) ? S_WB : S_INVAL;
        end
        S_WB: begin
          if (wb_ack_i) begin
            r_mask <= r_mask & ~w_way_oh;
            if (r_mask == w_way_oh) r_state <= S_INVAL;
          end
        end
        S_INVAL: begin
          if (sram_gnt_i) begin
            if (w_last_set) begin
              r_state <= S_ACK;
            end else begin
              r_set   <= r_set + IDX_W'(1);
              r_state <= S_READ;
            end
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag capture is pure datapath; it is only observed while in WB.
  always_ff @(posedge clk_i) begin
    if (r_state == S_CHECK) r_tags <= tag_i;
  end

  // A flush held high across the ack must be released before it can start another sweep.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_armed <= 1'b1;
    end else if (!flush_i) begin
      r_armed <= 1'b1;
    end else if (r_state == S_ACK) begin
      r_armed <= 1'b0;
    end
  end

  assign flushing_o   = (r_state == S_DRAIN) || (r_state == S_READ) || (r_state == S_CHECK) ||
                        (r_state == S_WB) || (r_state == S_INVAL);
  assign flush_ack_o  = (r_state == S_ACK);
  assign sram_req_o   = (r_state == S_READ) || (r_state == S_INVAL);
  assign sram_we_o    = (r_state == S_INVAL);
  assign sram_index_o = sram_req_o ? r_set : '0;
  assign wb_req_o     = w_in_wb;
  assign wb_index_o   = w_in_wb ? r_set : '0;
  assign wb_way_o     = w_in_wb ? w_way : '0;
  assign wb_tag_o     = w_in_wb ? w_tag : '0;

`ifdef DCACHE_FLUSH_WBCNT_EN
  logic [15:0] r_wb_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wb_cnt <= '0;
    end else if (w_start) begin
      r_wb_cnt <= '0;
    end else if (w_in_wb && wb_ack_i && (r_wb_cnt != 16'hFFFF)) begin
      r_wb_cnt <= r_wb_cnt + 16'd1;
    end
  end

  assign flush_wb_cnt_o = r_wb_cnt;
`else
  assign flush_wb_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with a 4-set, 2-way configuration and a behavioural tag/valid SRAM,
// grant and write-back responder. Cycle numbers are counted from the cycle flush_i is first driven high.
module tb_dcache_flush_ctrl;
  localparam int NS = 4;
  localparam int NW = 2;
  localparam int TW = 44;
  localparam int IW = 2;
  localparam int WW = 1;
  localparam int LW = IW + WW + TW;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           miss_busy_i = 1'b0;
  logic           sram_gnt_i = 1'b1;
  logic           wb_ack_i = 1'b0;
  logic [NW-1:0]  valid_i = '0;
  logic [NW-1:0]  dirty_i = '0;
  logic [NW*TW-1:0] tag_i = '0;
  logic           flushing_o, flush_ack_o, sram_req_o, sram_we_o, wb_req_o;
  logic [IW-1:0]  sram_index_o, wb_index_o;
  logic [WW-1:0]  wb_way_o;
  logic [TW-1:0]  wb_tag_o;
  logic [15:0]    flush_wb_cnt_o;

  dcache_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flushing_o(flushing_o),
    .flush_ack_o(flush_ack_o), .miss_busy_i(miss_busy_i), .sram_req_o(sram_req_o),
    .sram_we_o(sram_we_o), .sram_index_o(sram_index_o), .sram_gnt_i(sram_gnt_i),
    .valid_i(valid_i), .dirty_i(dirty_i), .tag_i(tag_i), .wb_req_o(wb_req_o),
    .wb_index_o(wb_index_o), .wb_way_o(wb_way_o), .wb_tag_o(wb_tag_o),
    .wb_ack_i(wb_ack_i), .flush_wb_cnt_o(flush_wb_cnt_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- memory model and observation logs ----------------
  logic [NW-1:0] mem_v [NS];
  logic [NW-1:0] mem_d [NS];
  logic [TW-1:0] mem_t [NS][NW];

  int          inval_q[$];
  int          inval_cyc_q[$];
  logic [LW-1:0] wb_q[$];
  int          wb_cyc_q[$];
  int          ack_cyc_q[$];
  logic [LW-1:0] exp_q[$];
  int flush_first, flush_last, flush_cnt, first_req, wb_req_cycles;
  int stall_set, stall_left, stall_seen, ack_delay, wb_wait;
  logic rd_pend = 1'b0;
  int   rd_idx = 0;

  task automatic clear_logs();
    inval_q.delete(); inval_cyc_q.delete(); wb_q.delete(); wb_cyc_q.delete();
    ack_cyc_q.delete(); exp_q.delete();
    flush_first = -1; flush_last = -1; flush_cnt = 0; first_req = -1; wb_req_cycles = 0;
    stall_set = 0; stall_left = 0; stall_seen = 0; ack_delay = 0; wb_wait = 0;
    t0 = cyc;
  endtask

  task automatic clear_mem();
    for (int s = 0; s < NS; s++) begin
      mem_v[s] = '1;
      mem_d[s] = '0;
      for (int w = 0; w < NW; w++) mem_t[s][w] = TW'(32'h0F00 + s * 16 + w);
    end
  endtask

  // Responder: SRAM read data one cycle after a granted read, grant stalls, write-back acks.
  always @(negedge clk) begin
    if (rd_pend) begin
      valid_i = mem_v[rd_idx];
      dirty_i = mem_d[rd_idx];
      for (int w = 0; w < NW; w++) tag_i[w*TW +: TW] = mem_t[rd_idx][w];
    end else begin
      valid_i = '0; dirty_i = '0; tag_i = '0;
    end
    rd_pend = 1'b0;
    sram_gnt_i = 1'b1;
    if (stall_left > 0 &&
        (stall_seen > 0 || (sram_req_o && !sram_we_o && sram_index_o == IW'(stall_set)))) begin
      sram_gnt_i = 1'b0;
      stall_left--;
      if (sram_req_o && !sram_we_o && sram_index_o == IW'(stall_set)) stall_seen++;
    end
    if (sram_req_o && first_req < 0) first_req = cyc - t0;
    if (sram_req_o && sram_gnt_i) begin
      if (sram_we_o) begin
        mem_v[sram_index_o] = '0;
        mem_d[sram_index_o] = '0;
        inval_q.push_back(int'(sram_index_o));
        inval_cyc_q.push_back(cyc - t0);
      end else begin
        rd_pend = 1'b1;
        rd_idx  = int'(sram_index_o);
      end
    end
    wb_ack_i = 1'b0;
    if (wb_req_o) begin
      wb_req_cycles++;
      if (wb_wait >= ack_delay) begin
        wb_ack_i = 1'b1;
        wb_q.push_back({wb_index_o, wb_way_o, wb_tag_o});
        wb_cyc_q.push_back(cyc - t0);
        wb_wait = 0;
      end else begin
        wb_wait++;
      end
    end else begin
      wb_wait = 0;
    end
    if (flushing_o) begin
      if (flush_first < 0) flush_first = cyc - t0;
      flush_last = cyc - t0;
      flush_cnt++;
    end
    if (flush_ack_o) ack_cyc_q.push_back(cyc - t0);
  end

  // ---------------- driver tasks ----------------
  task automatic start_flush();
    clear_logs();
    flush_i = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (flush_ack_o) seen = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [IW+IW+WW+TW+16+5-1:0] outs;
    rst_ni = 1'b0;
    idle(3);
    outs = {flushing_o, flush_ack_o, sram_req_o, sram_we_o, wb_req_o,
            sram_index_o, wb_index_o, wb_way_o, wb_tag_o, flush_wb_cnt_o};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2);
    checks++;
    if ({flushing_o, sram_req_o, wb_req_o, flush_ack_o} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 0000", {flushing_o, sram_req_o, wb_req_o, flush_ack_o});
    end
  endtask

  task automatic test_clean();
    bit seen;
    clear_mem();
    @(negedge clk);
    start_flush();
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL clean_ack_timeout: got none want ack"); end
    idle(3);
    checks++;
    if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 14) begin
      errors++; $display("FAIL clean_ack_cycle: got n=%0d c=%0d want n=1 c=14", ack_cyc_q.size(),
                         ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
    checks++;
    if (flush_first != 1 || flush_last != 13 || flush_cnt != 13) begin
      errors++; $display("FAIL clean_flushing: got %0d..%0d n=%0d want 1..13 n=13", flush_first, flush_last, flush_cnt);
    end
    checks++;
    if (inval_q.size() != NS) begin
      errors++; $display("FAIL clean_inval_count: got %0d want %0d", inval_q.size(), NS);
    end else begin
      for (int i = 0; i < NS; i++) begin
        checks++;
        if (inval_q[i] != i) begin
          errors++; $display("FAIL clean_inval_idx%0d: got %0d want %0d", i, inval_q[i], i);
        end
      end
    end
    checks++;
    if (wb_q.size() != 0) begin errors++; $display("FAIL clean_no_wb: got %0d want 0", wb_q.size()); end
  endtask

  task automatic test_single_wb();
    bit seen;
    logic [LW-1:0] exp_wb;
    clear_mem();
    mem_d[2][1]  = 1'b1;
    mem_t[2][1]  = 44'h1234;
    mem_t[2][0]  = 44'hAAAA;
    mem_v[1][0]  = 1'b0;   // dirty but invalid: ignored
    mem_d[1][0]  = 1'b1;
    @(negedge clk);
    start_flush();
    ack_delay = 2;
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL single_ack_timeout: got none want ack"); end
    idle(2);
    checks++;
    if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 17) begin
      errors++; $display("FAIL single_ack_cycle: got %0d want 17", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
    exp_wb = {2'd2, 1'b1, 44'h1234};
    checks++;
    if (wb_q.size() != 1 || wb_q[0] !== exp_wb) begin
      errors++; $display("FAIL single_wb: got n=%0d v=%h want n=1 v=%h", wb_q.size(),
                         wb_q.size() > 0 ? wb_q[0] : '0, exp_wb);
    end
    checks++;
    if (wb_req_cycles != 3 || wb_cyc_q.size() != 1 || wb_cyc_q[0] != 12) begin
      errors++; $display("FAIL single_wb_hold: got cycles=%0d want 3 ending at 12", wb_req_cycles);
    end
    checks++;
    if (inval_cyc_q.size() != NS || inval_cyc_q[2] != 13) begin
      errors++; $display("FAIL single_inval_set2: got n=%0d want set2 at 13", inval_cyc_q.size());
    end
    checks++;
`ifdef DCACHE_FLUSH_WBCNT_EN
    if (flush_wb_cnt_o !== 16'd1) begin errors++; $display("FAIL single_wbcnt: got %0d want 1", flush_wb_cnt_o); end
`else
    if (flush_wb_cnt_o !== 16'd0) begin errors++; $display("FAIL single_wbcnt: got %0d want 0", flush_wb_cnt_o); end
`endif
  endtask

  task automatic test_back_to_back();
    bit seen;
    clear_mem();
    mem_d[0]    = 2'b11;
    mem_t[0][0] = 44'h11;
    mem_t[0][1] = 44'h22;
    @(negedge clk);
    start_flush();
    exp_q.push_back({2'd0, 1'b0, 44'h11});
    exp_q.push_back({2'd0, 1'b1, 44'h22});
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || ack_cyc_q[0] != 16) begin
      errors++; $display("FAIL b2b_ack_cycle: got %0d want 16", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
    checks++;
    if (wb_q.size() != 2) begin
      errors++; $display("FAIL b2b_wb_count: got %0d want 2", wb_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wb_q[i] !== exp_q[i] || wb_cyc_q[i] != 4 + i) begin
          errors++; $display("FAIL b2b_wb%0d: got %h at %0d want %h at %0d", i, wb_q[i], wb_cyc_q[i], exp_q[i], 4 + i);
        end
      end
    end
    checks++;
    if (inval_q.size() == 0 || inval_q[0] != 0 || inval_cyc_q[0] != 6) begin
      errors++; $display("FAIL b2b_inval0: got n=%0d want set0 at 6", inval_q.size());
    end
    idle(1);
    checks++;
`ifdef DCACHE_FLUSH_WBCNT_EN
    if (flush_wb_cnt_o !== 16'd2) begin errors++; $display("FAIL b2b_wbcnt: got %0d want 2", flush_wb_cnt_o); end
`else
    if (flush_wb_cnt_o !== 16'd0) begin errors++; $display("FAIL b2b_wbcnt: got %0d want 0", flush_wb_cnt_o); end
`endif
  endtask

  task automatic test_gnt_stall();
    bit seen;
    clear_mem();
    @(negedge clk);
    start_flush();
    stall_set  = 1;
    stall_left = 5;
    wait_ack(50, seen);
    flush_i = 1'b0;
    checks++;
    if (stall_seen != 5) begin
      errors++; $display("FAIL stall_req_stable: got %0d want 5", stall_seen);
    end
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || ack_cyc_q[0] != 19) begin
      errors++; $display("FAIL stall_ack_cycle: got %0d want 19", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
    checks++;
    if (inval_q.size() != NS || inval_q[1] != 1 || inval_cyc_q[1] != 12) begin
      errors++; $display("FAIL stall_inval1: got n=%0d want set1 at 12", inval_q.size());
    end
  endtask

  task automatic test_busy();
    bit seen;
    clear_mem();
    @(negedge clk);
    start_flush();
    miss_busy_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) miss_busy_i = 1'b0;
    end
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (first_req != 11) begin errors++; $display("FAIL busy_first_req: got %0d want 11", first_req); end
    checks++;
    if (flush_first != 1) begin errors++; $display("FAIL busy_flushing_start: got %0d want 1", flush_first); end
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || ack_cyc_q[0] != 23) begin
      errors++; $display("FAIL busy_ack_cycle: got %0d want 23", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
  endtask

  task automatic test_rearm();
    bit seen;
    clear_mem();
    @(negedge clk);
    start_flush();
    wait_ack(40, seen);
    idle(4);
    flush_i = 1'b0;
    idle(6);
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || flush_cnt != 13) begin
      errors++; $display("FAIL rearm_no_second: got acks=%0d flushing=%0d want 1 and 13", ack_cyc_q.size(), flush_cnt);
    end
    @(negedge clk);
    start_flush();
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || ack_cyc_q[0] != 14) begin
      errors++; $display("FAIL rearm_new_sweep: got %0d want 14", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit hit;
    clear_mem();
    mem_d[0][0] = 1'b1;
    mem_t[0][0] = 44'h55;
    @(negedge clk);
    start_flush();
    ack_delay = 20;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (wb_req_o) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_wb_timeout: got none want wb_req"); end
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({flushing_o, flush_ack_o, sram_req_o, wb_req_o, wb_tag_o} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %b%b%b%b want 0000", flushing_o, flush_ack_o, sram_req_o, wb_req_o);
    end
    rst_ni = 1'b1;
    idle(20);
    checks++;
    if (ack_cyc_q.size() != 0 || flush_cnt != 4) begin
      errors++; $display("FAIL rstmid_no_ack: got acks=%0d flushing=%0d want 0 and 4", ack_cyc_q.size(), flush_cnt);
    end
    @(negedge clk);
    start_flush();
    wait_ack(40, seen);
    flush_i = 1'b0;
    checks++;
    if (!seen || ack_cyc_q.size() != 1 || ack_cyc_q[0] != 15) begin
      errors++; $display("FAIL rstmid_restart_ack: got %0d want 15", ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1);
    end
    checks++;
    if (wb_q.size() != 1 || wb_q[0] !== {2'd0, 1'b0, 44'h55} || inval_q.size() == 0 || inval_q[0] != 0) begin
      errors++; $display("FAIL rstmid_restart_set0: got wb n=%0d inval n=%0d want 1 wb of set0 then set0 inval",
                         wb_q.size(), inval_q.size());
    end
    idle(1);
    checks++;
`ifdef DCACHE_FLUSH_WBCNT_EN
    if (flush_wb_cnt_o !== 16'd1) begin errors++; $display("FAIL rstmid_wbcnt: got %0d want 1", flush_wb_cnt_o); end
`else
    if (flush_wb_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_wbcnt: got %0d want 0", flush_wb_cnt_o); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_logs();
    clear_mem();
    test_reset();
    test_clean();
    test_single_wb();
    test_back_to_back();
    test_gnt_stall();
    test_busy();
    test_rearm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
